// File: rtl/div_16_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude core, sign fix-up on completion).
module div_16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] step_prem, step_quo;
  logic [WIDTH-1:0] fin_quo, fin_rem;

  // The stored remainder is always < divisor, so WIDTH bits suffice; the
  // shifted trial value carries the extra bit whose borrow decides the quotient bit.
  assign shifted   = {prem_q, dvd_q[WIDTH-1]};
  assign diff      = shifted - {1'b0, dvs_q};
  assign step_prem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign step_quo  = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};

`ifdef DIV_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  assign a_mag   = a[WIDTH-1] ? -a : a;
  assign b_mag   = b[WIDTH-1] ? -b : b;
  assign fin_quo = negq_q ? -step_quo : step_quo;
  assign fin_rem = negr_q ? -step_prem : step_prem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  assign a_mag   = a;
  assign b_mag   = b;
  assign fin_quo = step_quo;
  assign fin_rem = step_prem;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pend_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      IDLE: begin
        // A zero divisor parks the raw dividend for one cycle, then reports.
        if (pend_q) begin
          done_d = 1'b1;
          dbz_d  = 1'b1;
          quo_d  = '1;
          rem_d  = dvd_q;
        end else if (start) begin
          if (b == '0) begin
            pend_d = 1'b1;
            dvd_d  = a;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            cnt_d   = CW'(WIDTH);
            prem_d  = '0;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
`ifdef DIV_SIGNED_EN
            negq_d  = a[WIDTH-1] ^ b[WIDTH-1];
            negr_d  = a[WIDTH-1];
`endif
          end
        end
      end
      RUN: begin
        prem_d = step_prem;
        dvd_d  = step_quo;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = fin_quo;
          rem_d   = fin_rem;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quo         = quo_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_16_seq.sv
// Directed bench for div_16_seq: vector table plus back-to-back, ignored-start and reset-abort sequences.
// Define DIV_SIGNED_EN to select the two's-complement expectations.
module tb_div_16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] quo;
  logic [15:0] rem;
  logic        div_by_zero;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] last_q = '0;
  logic [15:0] last_r = '0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  div_16_seq #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quo         (quo),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Caller is positioned at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input string nm, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                        input int elat, input int poke_at, input int rst_at);
    int  busy_cnt;
    bit  got;
    busy_cnt = 0;
    got = 0;
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom_range(0, 16'hFFFF));
    b = 16'($urandom_range(0, 16'hFFFF));
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (rst_at == j) begin
        rst_n = 1'b0;
        #1;
        chk({nm, "_rst_busy"}, 32'(busy), 32'd0);
        chk({nm, "_rst_done"}, 32'(done), 32'd0);
        chk({nm, "_rst_quo"}, 32'(quo), 32'd0);
        chk({nm, "_rst_rem"}, 32'(rem), 32'd0);
        chk({nm, "_rst_dbz"}, 32'(div_by_zero), 32'd0);
        repeat (3) begin
          @(negedge clk);
          chk({nm, "_rst_nodone"}, 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) begin
          @(negedge clk);
          chk({nm, "_post_rst_nodone"}, 32'(done), 32'd0);
        end
        last_q = '0;
        last_r = '0;
        return;
      end
      if (busy) busy_cnt++;
      if (j == 0) begin
        chk({nm, "_hold_quo"}, 32'(quo), 32'(last_q));
        chk({nm, "_hold_rem"}, 32'(rem), 32'(last_r));
      end
      if (done) begin
        got = 1;
        chk({nm, "_latency"}, 32'(j), 32'(elat));
        break;
      end
      if (poke_at == j) begin
        a = 16'h0001;
        b = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    if (!got) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_quo"}, 32'(quo), 32'(eq));
      chk({nm, "_rem"}, 32'(rem), 32'(er));
      chk({nm, "_dbz"}, 32'(div_by_zero), 32'(edbz));
      chk({nm, "_busy_cycles"}, 32'(busy_cnt), edbz ? 32'd0 : 32'(elat));
    end
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    vecs[0] = '{"basic",   16'h3453, 16'h1231, 16'h0002, 16'h0FF1, 1'b0, 16};
    vecs[1] = '{"eq_max",  16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16};
    vecs[2] = '{"zero_a",  16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 16};
    vecs[3] = '{"dbz",     16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1};
    vecs[4] = '{"ff_16",   16'h00FF, 16'h0010, 16'h000F, 16'h000F, 1'b0, 16};
`ifdef DIV_SIGNED_EN
    vecs[5] = '{"min_3",   16'h8000, 16'h0003, 16'hD556, 16'hFFFE, 1'b0, 16};
    vecs[6] = '{"neg7_2",  16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 16};
    vecs[7] = '{"ovf",     16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 16};
`else
    vecs[5] = '{"min_3",   16'h8000, 16'h0003, 16'h2AAA, 16'h0002, 1'b0, 16};
    vecs[6] = '{"neg7_2",  16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, 16};
    vecs[7] = '{"ovf",     16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 16};
`endif

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quo", 32'(quo), 32'd0);
    chk("reset_rem", 32'(rem), 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
             vecs[i].dbz, vecs[i].lat, -1, -1);
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
    end

    // start-on-done: second op launched in the done cycle of the first
    run_op("b2b_first", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16, -1, -1);
    run_op("b2b_second", 16'h0005, 16'h0007, 16'h0000, 16'h0005, 1'b0, 16, -1, -1);
    @(negedge clk);

    // start while busy must be ignored
    run_op("ignored_start", 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 16, 5, -1);
    @(negedge clk);

    // reset mid-run aborts, then a clean run follows
    run_op("abort", 16'h3453, 16'h1231, 16'h0002, 16'h0FF1, 1'b0, 16, -1, 8);
    run_op("after_abort", 16'h0010, 16'h0004, 16'h0004, 16'h0000, 1'b0, 16, -1, -1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
